adc_ring_writer: RTL

Sample-rate scheduler and decimating ring-buffer writer between the XADC capture block and the data RAM's ADC write-only port. It generates the periodic sample tick, box-car averages 2^AVG_LOG2 raw EMG/ECG readings per channel, and writes each averaged pair into two fixed circular regions of data RAM. It also publishes the ring write index so the CPU and VGA reader can locate the newest sample.

---
 rtl/adc_ring_writer_if.sv | 20 ++
 rtl/adc_ring_writer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/adc_ring_writer_if.sv
// Data RAM ADC write-only port: a single-beat word write with enable, address and data.
interface adc_ring_writer_if;
  logic        adc_wEn;
  logic [11:0] adc_addr;
  logic [31:0] adc_dataIn;

  // Driven by the ring writer.
  modport master (
    output adc_wEn,
    output adc_addr,
    output adc_dataIn
  );

  // Observed by the RAM port (or a monitor).
  modport slave (
    input adc_wEn,
    input adc_addr,
    input adc_dataIn
  );
endinterface

// File: rtl/adc_ring_writer.sv
// Sample-rate scheduler and decimating ring-buffer writer. A free-running counter produces
// a periodic tick; each unfrozen tick adds the raw EMG/ECG readings into box-car
// accumulators. Every 2^AVG_LOG2 accumulated ticks the averaged pair is written to two
// circular regions of data RAM on consecutive cycles, and the ring index is published.
module adc_ring_writer #(
  parameter int unsigned SAMPLE_INTERVAL = 125000,
  parameter int unsigned AVG_LOG2        = 2,
  parameter int unsigned DEPTH           = 640,
  parameter logic [11:0] EMG_BASE        = 12'h400,
  parameter logic [11:0] ECG_BASE        = 12'h800
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [15:0]             emg_in,
  input  logic [15:0]             ecg_in,
  input  logic                    freeze,
  adc_ring_writer_if.master       ram,
  output logic [9:0]              wr_index,
  output logic                    wrap,
  output logic                    busy
);

  localparam int unsigned TickW = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam int unsigned AccW  = 16 + AVG_LOG2;
  // AVG_LOG2 = 0 would give a zero-width counter; keep one bit that never leaves 0.
  localparam int unsigned CntW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [TickW-1:0] TickLast = TickW'(SAMPLE_INTERVAL - 1);
  localparam logic [CntW-1:0]  AvgLast  = CntW'((1 << AVG_LOG2) - 1);
  localparam logic [9:0]       IdxLast  = 10'(DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWrEmg,
    StWrEcg
  } state_e;

  state_e            state;
  logic [TickW-1:0]  tick_cnt;
  logic [CntW-1:0]   avg_cnt;
  logic [AccW-1:0]   acc_emg;
  logic [AccW-1:0]   acc_ecg;
  logic [9:0]        idx;

  logic              tick;
  logic [AccW-1:0]   emg_sum;
  logic [AccW-1:0]   ecg_sum;
  logic [15:0]       emg_avg_new;
  logic [15:0]       ecg_avg;
  logic [11:0]       emg_addr;
  logic [11:0]       ecg_addr;

  assign tick     = (tick_cnt == TickLast);
  assign emg_sum  = acc_emg + AccW'(emg_in);
  assign ecg_sum  = acc_ecg + AccW'(ecg_in);
  // The EMG word is registered on the final tick itself, so it must include that tick's sample.
  assign emg_avg_new = 16'(emg_sum >> AVG_LOG2);
  // By the ECG write the accumulator already holds the full sum.
  assign ecg_avg  = 16'(acc_ecg >> AVG_LOG2);
  assign emg_addr = EMG_BASE + {2'b00, idx};
  assign ecg_addr = ECG_BASE + {2'b00, idx};

  // Free-running sample-tick counter, independent of freeze and FSM state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Accumulate/write FSM with all outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= StIdle;
      avg_cnt        <= '0;
      acc_emg        <= '0;
      acc_ecg        <= '0;
      idx            <= '0;
      ram.adc_wEn    <= 1'b0;
      ram.adc_addr   <= '0;
      ram.adc_dataIn <= '0;
      wr_index       <= '0;
      wrap           <= 1'b0;
      busy           <= 1'b0;
    end else begin
      wrap <= 1'b0;
      unique case (state)
        StIdle: begin
          if (tick && !freeze) begin
            acc_emg <= emg_sum;
            acc_ecg <= ecg_sum;
            if (avg_cnt == AvgLast) begin
              avg_cnt        <= '0;
              state          <= StWrEmg;
              ram.adc_wEn    <= 1'b1;
              ram.adc_addr   <= emg_addr;
              ram.adc_dataIn <= {16'h0000, emg_avg_new};
              busy           <= 1'b1;
            end else begin
              avg_cnt <= avg_cnt + 1'b1;
            end
          end
        end
        StWrEmg: begin
          state          <= StWrEcg;
          ram.adc_addr   <= ecg_addr;
          ram.adc_dataIn <= {16'h0000, ecg_avg};
        end
        StWrEcg: begin
          state       <= StIdle;
          ram.adc_wEn <= 1'b0;
          busy        <= 1'b0;
          acc_emg     <= '0;
          acc_ecg     <= '0;
          wr_index    <= idx;
          wrap        <= (idx == IdxLast);
          idx         <= (idx == IdxLast) ? '0 : idx + 1'b1;
        end
        default: begin
          state       <= StIdle;
          ram.adc_wEn <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
